// File: rtl/gpr_wb_queue.sv
// Writeback scheduler for the single GPR write port: execute results win, and load returns wait
// in a small kill-aware FIFO. Also provides a write-stage bypass and busy flags for issue.
module gpr_wb_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ex_val,
  input  logic [4:0]                 ex_adr,
  input  logic [31:0]                ex_dat,
  input  logic                       ld_val,
  output logic                       ld_rdy,
  input  logic [4:0]                 ld_adr,
  input  logic [31:0]                ld_dat,
  output logic                       wr_en_0,
  output logic [4:0]                 wr_adr_0,
  output logic [31:0]                wr_dat_0,
  input  logic [4:0]                 byp_adr_0,
  input  logic [4:0]                 byp_adr_1,
  input  logic [4:0]                 byp_adr_2,
  output logic                       byp_hit_0,
  output logic                       byp_hit_1,
  output logic                       byp_hit_2,
  output logic [31:0]                byp_dat_0,
  output logic [31:0]                byp_dat_1,
  output logic [31:0]                byp_dat_2,
  output logic                       busy_0,
  output logic                       busy_1,
  output logic                       busy_2,
  output logic [$clog2(DEPTH):0]     cnt,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]       adr_q [DEPTH];
  logic [31:0]      dat_q [DEPTH];
  logic [PtrW-1:0]  head_q, tail_q;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             wr_en_q, wr_en_d;
  logic [4:0]       wr_adr_q, wr_adr_d;
  logic [31:0]      wr_dat_q, wr_dat_d;

  logic ld_acc, pop, direct, push, push_live;

  assign full   = (cnt_q == CntW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign cnt    = cnt_q;
  assign ld_rdy = !full;

  assign ld_acc    = ld_val && ld_rdy;
  assign pop       = !ex_val && !empty;
  assign direct    = !ex_val && empty && ld_acc;
  assign push      = ld_acc && !direct;
  // The load is older than a concurrent ex write to the same register, so it enters dead.
  assign push_live = !(ex_val && (ld_adr == ex_adr));

  always_comb begin
    wr_en_d  = 1'b0;
    wr_adr_d = ld_adr;
    wr_dat_d = ld_dat;
    if (ex_val) begin
      wr_en_d  = 1'b1;
      wr_adr_d = ex_adr;
      wr_dat_d = ex_dat;
    end else if (!empty) begin
      wr_en_d  = live_q[head_q];
      wr_adr_d = adr_q[head_q];
      wr_dat_d = dat_q[head_q];
    end else if (ld_acc) begin
      wr_en_d  = 1'b1;
    end
  end

  // Live bits are cleared on pop too, so live alone marks an occupied, pending entry.
  always_comb begin
    live_d = live_q;
    if (ex_val) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adr_q[i] == ex_adr) live_d[i] = 1'b0;
      end
    end
    if (pop)  live_d[head_q] = 1'b0;
    if (push) live_d[tail_q] = push_live;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CntW'(1);
    else if (pop && !push) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      wr_en_q  <= 1'b0;
      wr_adr_q <= '0;
      wr_dat_q <= '0;
    end else begin
      live_q  <= live_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      if (pop)  head_q <= head_q + PtrW'(1);
      if (push) tail_q <= tail_q + PtrW'(1);
      if (wr_en_d) begin
        wr_adr_q <= wr_adr_d;
        wr_dat_q <= wr_dat_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      adr_q[tail_q] <= ld_adr;
      dat_q[tail_q] <= ld_dat;
    end
  end

  assign wr_en_0  = wr_en_q;
  assign wr_adr_0 = wr_adr_q;
  assign wr_dat_0 = wr_dat_q;

  logic [4:0] rd_adr [3];
  logic [2:0] busy_v, hit_v;

  assign rd_adr[0] = byp_adr_0;
  assign rd_adr[1] = byp_adr_1;
  assign rd_adr[2] = byp_adr_2;

  always_comb begin
    busy_v = '0;
    hit_v  = '0;
    for (int k = 0; k < 3; k++) begin
      hit_v[k] = wr_en_q && (wr_adr_q == rd_adr[k]);
      for (int i = 0; i < DEPTH; i++) begin
        if (live_q[i] && (adr_q[i] == rd_adr[k])) busy_v[k] = 1'b1;
      end
    end
  end

  assign byp_hit_0 = hit_v[0];
  assign byp_hit_1 = hit_v[1];
  assign byp_hit_2 = hit_v[2];
  assign byp_dat_0 = hit_v[0] ? wr_dat_q : '0;
  assign byp_dat_1 = hit_v[1] ? wr_dat_q : '0;
  assign byp_dat_2 = hit_v[2] ? wr_dat_q : '0;
  assign busy_0    = busy_v[0];
  assign busy_1    = busy_v[1];
  assign busy_2    = busy_v[2];

endmodule
